// File: rtl/dmem_responder.sv
// Data-memory responder for the RV32I load/store port: one request at a time,
// word RAM with byte lanes, programmable wait states and a pipeline stall request.
module dmem_responder #(
  parameter int ADRS_W      = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_adrs,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        stall_req
);

  localparam int DEPTH = 1 << ADRS_W;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]        state;
  logic [3:0]        wait_cnt;
  logic              lat_we;
  logic [2:0]        lat_funct3;
  logic [31:0]       lat_adrs;
  logic [31:0]       lat_wdata;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic [31:0]       mem [DEPTH];

  logic [ADRS_W-1:0] word_idx;
  logic [1:0]        byte_off;
  logic              bad_funct3;
  logic              misaligned;
  logic              out_of_range;
  logic              access_err;
  logic              do_access;
  logic [3:0]        byte_en;
  logic [31:0]       wdata_rep;
  logic [31:0]       rd_word;
  logic [31:0]       rd_shifted;
  logic [7:0]        sel_byte;
  logic [15:0]       sel_half;
  logic [31:0]       load_data;
  logic [31:0]       rsp_next;

  assign word_idx  = lat_adrs[ADRS_W+1:2];
  assign byte_off  = lat_adrs[1:0];
  assign do_access = (state == WAIT) && (wait_cnt == 4'd0);

  // Rejection checks are evaluated on the latched request only.
  always_comb begin
    bad_funct3   = (lat_funct3 == 3'd3) || (lat_funct3 == 3'd6) ||
                   (lat_funct3 == 3'd7) || (lat_funct3[2] && lat_we);
    misaligned   = ((lat_funct3[1:0] == 2'b01) && lat_adrs[0]) ||
                   ((lat_funct3[1:0] == 2'b10) && (lat_adrs[1:0] != 2'b00));
    out_of_range = |(lat_adrs >> (ADRS_W + 2));
    access_err   = bad_funct3 || misaligned || out_of_range;
  end

  // Store data is replicated across lanes so the byte enables alone pick what lands.
  always_comb begin
    byte_en   = 4'b0000;
    wdata_rep = lat_wdata;
    case (lat_funct3[1:0])
      2'b00: begin
        byte_en   = 4'b0001 << byte_off;
        wdata_rep = {4{lat_wdata[7:0]}};
      end
      2'b01: begin
        byte_en   = byte_off[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{lat_wdata[15:0]}};
      end
      2'b10: begin
        byte_en   = 4'b1111;
        wdata_rep = lat_wdata;
      end
      default: begin
        byte_en   = 4'b0000;
        wdata_rep = lat_wdata;
      end
    endcase
  end

  always_comb begin
    rd_word    = mem[word_idx];
    rd_shifted = rd_word >> {byte_off, 3'b000};
    sel_byte   = rd_shifted[7:0];
    sel_half   = byte_off[1] ? rd_word[31:16] : rd_word[15:0];
    load_data  = 32'd0;
    case (lat_funct3)
      3'd0:    load_data = {{24{sel_byte[7]}}, sel_byte};
      3'd1:    load_data = {{16{sel_half[15]}}, sel_half};
      3'd2:    load_data = rd_word;
      3'd4:    load_data = {24'd0, sel_byte};
      3'd5:    load_data = {16'd0, sel_half};
      default: load_data = 32'd0;
    endcase
    rsp_next = (access_err || lat_we) ? 32'd0 : load_data;
  end

  // A reset on the access edge suppresses the write so an aborted store never lands.
  always_ff @(posedge clk) begin
    if (!reset && do_access && lat_we && !access_err) begin
      for (int k = 0; k < 4; k++) begin
        if (byte_en[k]) begin
          mem[word_idx][8*k +: 8] <= wdata_rep[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      wait_cnt   <= 4'd0;
      lat_we     <= 1'b0;
      lat_funct3 <= 3'd0;
      lat_adrs   <= 32'd0;
      lat_wdata  <= 32'd0;
      rdata_q    <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_we     <= req_we;
            lat_funct3 <= req_funct3;
            lat_adrs   <= req_adrs;
            lat_wdata  <= req_wdata;
            wait_cnt   <= 4'(WAIT_STATES);
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else begin
            rdata_q <= rsp_next;
            err_q   <= access_err;
            state   <= RESP;
          end
        end
        RESP: begin
          rdata_q <= 32'd0;
          err_q   <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          rdata_q <= 32'd0;
          err_q   <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // Stall drops in RESP so the pipeline captures the response on that cycle's edge.
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign stall_req = ((state == IDLE) && req_valid) || (state == WAIT);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances with 1, 3 and 0 wait states,
// a vector table on the first and hand-written sequences for reset-abort and back-to-back.
module tb_dmem_responder;

  logic        clk;
  logic        reset      [3];
  logic        req_valid  [3];
  logic        req_we     [3];
  logic [2:0]  req_funct3 [3];
  logic [31:0] req_adrs   [3];
  logic [31:0] req_wdata  [3];
  logic        rsp_valid  [3];
  logic [31:0] rsp_rdata  [3];
  logic        rsp_err    [3];
  logic        stall_req  [3];

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] adrs;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    string       name;
  } vec_t;

  vec_t vecs [24];

  dmem_responder #(.ADRS_W(10), .WAIT_STATES(1)) dut_ws1 (
    .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_we(req_we[0]),
    .req_funct3(req_funct3[0]), .req_adrs(req_adrs[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
    .stall_req(stall_req[0])
  );

  dmem_responder #(.ADRS_W(10), .WAIT_STATES(3)) dut_ws3 (
    .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_we(req_we[1]),
    .req_funct3(req_funct3[1]), .req_adrs(req_adrs[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
    .stall_req(stall_req[1])
  );

  dmem_responder #(.ADRS_W(10), .WAIT_STATES(0)) dut_ws0 (
    .clk(clk), .reset(reset[2]), .req_valid(req_valid[2]), .req_we(req_we[2]),
    .req_funct3(req_funct3[2]), .req_adrs(req_adrs[2]), .req_wdata(req_wdata[2]),
    .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]),
    .stall_req(stall_req[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int wsOf(input int d);
    if (d == 0) return 1;
    if (d == 1) return 3;
    return 0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual === expected) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Present one request, hold it through RESP, and check stall/latency per cycle.
  task automatic applyStimulus(input int d, input logic we, input logic [2:0] f3,
                               input logic [31:0] adrs, input logic [31:0] wdata,
                               input string name,
                               output logic [31:0] rdata, output logic err);
    int lat;
    bit got;
    lat   = 99;
    got   = 0;
    rdata = 32'hBAD0BAD0;
    err   = 1'b0;
    @(negedge clk);
    req_valid[d]  = 1'b1;
    req_we[d]     = we;
    req_funct3[d] = f3;
    req_adrs[d]   = adrs;
    req_wdata[d]  = wdata;
    #1;
    checkOutput({name, " stall on request"}, 32'(stall_req[d]), 32'd1);
    checkOutput({name, " no early rsp"}, 32'(rsp_valid[d]), 32'd0);
    for (int c = 1; c <= 40; c++) begin
      if (!got) begin
        @(negedge clk);
        #1;
        if (rsp_valid[d]) begin
          got   = 1;
          lat   = c;
          rdata = rsp_rdata[d];
          err   = rsp_err[d];
          checkOutput({name, " stall low in RESP"}, 32'(stall_req[d]), 32'd0);
        end else begin
          checkOutput({name, " stall in WAIT"}, 32'(stall_req[d]), 32'd1);
        end
      end
    end
    checkOutput({name, " latency"}, 32'(lat), 32'(2 + wsOf(d)));
  endtask

  logic [31:0] rd;
  logic        er;

  initial begin
    for (int d = 0; d < 3; d++) begin
      reset[d]      = 1'b1;
      req_valid[d]  = 1'b0;
      req_we[d]     = 1'b0;
      req_funct3[d] = 3'd0;
      req_adrs[d]   = 32'd0;
      req_wdata[d]  = 32'd0;
    end

    vecs[0]  = '{1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, "sw 0x100"};
    vecs[1]  = '{1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, "lw 0x100"};
    vecs[2]  = '{1'b1, 3'd0, 32'h102, 32'hAAAAAA55, 32'h0, 1'b0, "sb 0x102"};
    vecs[3]  = '{1'b0, 3'd2, 32'h100, 32'h0, 32'hDE55BEEF, 1'b0, "lw after sb"};
    vecs[4]  = '{1'b0, 3'd0, 32'h102, 32'h0, 32'h00000055, 1'b0, "lb 0x102"};
    vecs[5]  = '{1'b0, 3'd4, 32'h103, 32'h0, 32'h000000DE, 1'b0, "lbu 0x103"};
    vecs[6]  = '{1'b0, 3'd1, 32'h102, 32'h0, 32'hFFFFDE55, 1'b0, "lh 0x102"};
    vecs[7]  = '{1'b0, 3'd5, 32'h100, 32'h0, 32'h0000BEEF, 1'b0, "lhu 0x100"};
    vecs[8]  = '{1'b0, 3'd2, 32'h101, 32'h0, 32'h0, 1'b1, "lw misaligned"};
    vecs[9]  = '{1'b1, 3'd1, 32'h103, 32'h00001111, 32'h0, 1'b1, "sh misaligned"};
    vecs[10] = '{1'b0, 3'd2, 32'h100, 32'h0, 32'hDE55BEEF, 1'b0, "lw after bad sh"};
    vecs[11] = '{1'b0, 3'd2, 32'h1000, 32'h0, 32'h0, 1'b1, "lw out of range"};
    vecs[12] = '{1'b0, 3'd3, 32'h100, 32'h0, 32'h0, 1'b1, "funct3 3"};
    vecs[13] = '{1'b0, 3'd0, 32'h101, 32'h0, 32'hFFFFFFBE, 1'b0, "lb sign 0x101"};
    vecs[14] = '{1'b1, 3'd1, 32'h102, 32'hFFFF8001, 32'h0, 1'b0, "sh 0x102"};
    vecs[15] = '{1'b0, 3'd2, 32'h100, 32'h0, 32'h8001BEEF, 1'b0, "lw after sh"};
    vecs[16] = '{1'b0, 3'd1, 32'h100, 32'h0, 32'hFFFFBEEF, 1'b0, "lh 0x100"};
    vecs[17] = '{1'b0, 3'd5, 32'h102, 32'h0, 32'h00008001, 1'b0, "lhu 0x102"};
    vecs[18] = '{1'b1, 3'd4, 32'h100, 32'h11111111, 32'h0, 1'b1, "store funct3 4"};
    vecs[19] = '{1'b0, 3'd7, 32'h100, 32'h0, 32'h0, 1'b1, "funct3 7"};
    vecs[20] = '{1'b0, 3'd2, 32'h100, 32'h0, 32'h8001BEEF, 1'b0, "lw unchanged"};
    vecs[21] = '{1'b1, 3'd2, 32'hFFC, 32'hA5A50001, 32'h0, 1'b0, "sw top word"};
    vecs[22] = '{1'b0, 3'd2, 32'hFFC, 32'h0, 32'hA5A50001, 1'b0, "lw top word"};
    vecs[23] = '{1'b0, 3'd2, 32'h80000000, 32'h0, 32'h0, 1'b1, "lw high adrs"};

    repeat (2) @(negedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      checkOutput("reset rsp_valid", 32'(rsp_valid[d]), 32'd0);
      checkOutput("reset rsp_rdata", rsp_rdata[d], 32'd0);
      checkOutput("reset rsp_err", 32'(rsp_err[d]), 32'd0);
      checkOutput("reset stall_req", 32'(stall_req[d]), 32'd0);
    end
    for (int d = 0; d < 3; d++) reset[d] = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("idle stall_req", 32'(stall_req[0]), 32'd0);
    checkOutput("idle rsp_valid", 32'(rsp_valid[0]), 32'd0);

    for (int i = 0; i < 24; i++) begin
      applyStimulus(0, vecs[i].we, vecs[i].f3, vecs[i].adrs, vecs[i].wdata,
                    vecs[i].name, rd, er);
      checkOutput({vecs[i].name, " rdata"}, rd, vecs[i].exp_rdata);
      checkOutput({vecs[i].name, " err"}, 32'(er), 32'(vecs[i].exp_err));
    end
    @(negedge clk);
    req_valid[0] = 1'b0;

    // Reset while a store waits must discard it.
    applyStimulus(1, 1'b1, 3'd2, 32'h200, 32'hCAFEF00D, "ws3 sw prior", rd, er);
    checkOutput("ws3 sw prior err", 32'(er), 32'd0);
    @(negedge clk);
    req_we[1]     = 1'b1;
    req_funct3[1] = 3'd2;
    req_adrs[1]   = 32'h200;
    req_wdata[1]  = 32'h12345678;
    req_valid[1]  = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("ws3 abort in WAIT", 32'(stall_req[1]), 32'd1);
    reset[1]     = 1'b1;
    req_valid[1] = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("ws3 post-reset stall", 32'(stall_req[1]), 32'd0);
    checkOutput("ws3 post-reset rsp_valid", 32'(rsp_valid[1]), 32'd0);
    checkOutput("ws3 post-reset rdata", rsp_rdata[1], 32'd0);
    checkOutput("ws3 post-reset err", 32'(rsp_err[1]), 32'd0);
    reset[1] = 1'b0;
    applyStimulus(1, 1'b0, 3'd2, 32'h200, 32'h0, "ws3 lw after abort", rd, er);
    checkOutput("ws3 aborted store not written", rd, 32'hCAFEF00D);
    checkOutput("ws3 lw err", 32'(er), 32'd0);
    @(negedge clk);
    req_valid[1] = 1'b0;

    // Back-to-back requests with req_valid held high through RESP.
    applyStimulus(2, 1'b1, 3'd2, 32'h10, 32'h0BADF00D, "ws0 sw", rd, er);
    checkOutput("ws0 sw rdata", rd, 32'd0);
    applyStimulus(2, 1'b0, 3'd2, 32'h10, 32'h0, "ws0 lw", rd, er);
    checkOutput("ws0 lw rdata", rd, 32'h0BADF00D);
    applyStimulus(2, 1'b0, 3'd4, 32'h13, 32'h0, "ws0 lbu", rd, er);
    checkOutput("ws0 lbu rdata", rd, 32'h0000000B);
    @(negedge clk);
    req_valid[2] = 1'b0;
    #1;
    checkOutput("ws0 no duplicate rsp", 32'(rsp_valid[2]), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      checkOutput("ws0 quiet rsp_valid", 32'(rsp_valid[2]), 32'd0);
      checkOutput("ws0 quiet stall", 32'(stall_req[2]), 32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
